// File: rtl/reg_file_sb.sv
// Purpose: register file with per-register busy scoreboard, writeback bypass and busy count.
// Latency: reads combinational; writes and busy updates take effect at the next rising edge.
// Backpressure: none; every write, issue and flush is accepted each cycle (ignored in reset).
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   rd_addr_{1,2}_in -> rd_data_{1,2}_out, rd_busy_{1,2}_out (combinational read ports)
//   wr_en_in / wr_addr_in / wr_data_in : writeback, clears the busy bit
//   iss_en_in / iss_addr_in             : issue, sets the busy bit
//   flush_in                            : clears every busy bit
//   busy_cnt_out                        : registered number of set busy bits
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int SP_IDX   = 29,
  parameter int SP_RST   = 128,
  parameter int BYPASS   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rd_addr_1_in,
  input  logic [ADDR_W-1:0] rd_addr_2_in,
  output logic [DATA_W-1:0] rd_data_1_out,
  output logic [DATA_W-1:0] rd_data_2_out,
  output logic              rd_busy_1_out,
  output logic              rd_busy_2_out,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              iss_en_in,
  input  logic [ADDR_W-1:0] iss_addr_in,
  input  logic              flush_in,
  output logic [ADDR_W:0]   busy_cnt_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Address 0 is hardwired when ZERO_REG is set; writes/issues to it are dropped.
  logic wr_ok;
  logic iss_set;
  logic wr_clr;
  logic cnt_inc;
  logic cnt_dec;

  always_comb begin
    wr_ok   = wr_en_in  && !((ZERO_REG != 0) && (wr_addr_in  == '0));
    iss_set = iss_en_in && !((ZERO_REG != 0) && (iss_addr_in == '0)) && !flush_in;
    // A same-address issue wins over the writeback clear.
    wr_clr  = wr_ok && !flush_in && !(iss_set && (iss_addr_in == wr_addr_in));
    // Count only real transitions so repeated issues / idle writebacks are neutral.
    cnt_inc = iss_set && !busy[iss_addr_in];
    cnt_dec = wr_clr  &&  busy[wr_addr_in];
  end

  // Returns {busy, data} for one read port.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    r = {busy[a], regs[a]};
    if ((ZERO_REG != 0) && (a == '0)) begin
      r = '0;
    end else if ((BYPASS != 0) && wr_en_in && (wr_addr_in == a)) begin
      // Forwarded value is the producer's result, so the register is no longer
      // waiting on it unless a new producer is issued to it this same cycle.
      r = {iss_en_in && (iss_addr_in == a), wr_data_in};
    end
    return r;
  endfunction

  always_comb begin
    {rd_busy_1_out, rd_data_1_out} = read_port(rd_addr_1_in);
    {rd_busy_2_out, rd_data_2_out} = read_port(rd_addr_2_in);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RST) : '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr_in] <= wr_data_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy         <= '0;
      busy_cnt_out <= '0;
    end else if (flush_in) begin
      busy         <= '0;
      busy_cnt_out <= '0;
    end else begin
      if (wr_clr) begin
        busy[wr_addr_in] <= 1'b0;
      end
      if (iss_set) begin
        busy[iss_addr_in] <= 1'b1;
      end
      busy_cnt_out <= busy_cnt_out + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Purpose: directed self-checking bench for reg_file_sb (bypass and non-bypass instances).
// Latency: checks sampled 1-2 time units after the rising edge, away from the clock.
// Backpressure: none; stimulus driven with blocking assignments on a fixed schedule.
module tb_reg_file_sb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rd_addr_1, rd_addr_2, wr_addr, iss_addr;
  logic [31:0] wr_data;
  logic        wr_en, iss_en, flush;
  logic [31:0] d1, d2, nb_d1, nb_d2;
  logic        b1, b2, nb_b1, nb_b2;
  logic [5:0]  cnt, nb_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  reg_file_sb u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_addr_1_in(rd_addr_1), .rd_addr_2_in(rd_addr_2),
    .rd_data_1_out(d1), .rd_data_2_out(d2),
    .rd_busy_1_out(b1), .rd_busy_2_out(b2),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .iss_en_in(iss_en), .iss_addr_in(iss_addr),
    .flush_in(flush), .busy_cnt_out(cnt)
  );

  reg_file_sb #(.BYPASS(0)) u_nb (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_addr_1_in(rd_addr_1), .rd_addr_2_in(rd_addr_2),
    .rd_data_1_out(nb_d1), .rd_data_2_out(nb_d2),
    .rd_busy_1_out(nb_b1), .rd_busy_2_out(nb_b2),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .iss_en_in(iss_en), .iss_addr_in(iss_addr),
    .flush_in(flush), .busy_cnt_out(nb_cnt)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    // Reset asserted before the first clock edge.
    #1;
    for (int i = 0; i < 32; i++) begin
      rd_addr_1 = 5'(i);
      #1;
      exp = (i == 29) ? 32'd128 : 32'd0;
      checks++;
      if (d1 !== exp || b1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_reg%0d data=%h busy=%b expected data=%h busy=0", i, d1, b1, exp);
      end
    end
    checks++;
    if (cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d expected=0", cnt);
    end
    // Writes and issues during reset are ignored.
    step();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77; iss_en = 1'b1; iss_addr = 5'd6;
    step();
    idle();
    rd_addr_1 = 5'd5; rd_addr_2 = 5'd6;
    #1;
    checks++;
    if (d1 !== 32'd0 || b2 !== 1'b0 || cnt !== 6'd0) begin
      errors++;
      $display("FAIL reset_ignore r5=%h busy6=%b cnt=%0d expected r5=0 busy6=0 cnt=0", d1, b2, cnt);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_bypass();
    step();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr_1 = 5'd5;
    #1;
    checks++;
    if (d1 !== 32'hDEADBEEF || b1 !== 1'b0) begin
      errors++;
      $display("FAIL bypass_same_cycle data=%h busy=%b expected data=deadbeef busy=0", d1, b1);
    end
    checks++;
    if (nb_d1 !== 32'd0) begin
      errors++;
      $display("FAIL nobypass_same_cycle data=%h expected=0", nb_d1);
    end
    step();
    idle();
    #1;
    checks++;
    if (d1 !== 32'hDEADBEEF || nb_d1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_stored data=%h nb_data=%h expected deadbeef", d1, nb_d1);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; iss_en = 1'b1; iss_addr = 5'd0;
    rd_addr_1 = 5'd0;
    #1;
    checks++;
    if (d1 !== 32'd0 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_same_cycle data=%h busy=%b expected 0/0", d1, b1);
    end
    step();
    idle();
    #1;
    checks++;
    if (d1 !== 32'd0 || b1 !== 1'b0 || cnt !== 6'd0) begin
      errors++;
      $display("FAIL zero_after data=%h busy=%b cnt=%0d expected 0/0/0", d1, b1, cnt);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 5'd3; step();
    iss_addr = 5'd7; step();
    iss_addr = 5'd3; step();
    idle();
    rd_addr_1 = 5'd3; rd_addr_2 = 5'd7;
    #1;
    checks++;
    if (cnt !== 6'd2 || b1 !== 1'b1 || b2 !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue cnt=%0d b3=%b b7=%b expected 2/1/1", cnt, b1, b2);
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3333;
    #1;
    checks++;
    if (b1 !== 1'b0 || d1 !== 32'h3333 || nb_b1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb_bypass b3=%b d3=%h nb_b3=%b expected 0/3333/1", b1, d1, nb_b1);
    end
    step();
    idle();
    #1;
    checks++;
    if (cnt !== 6'd1 || b1 !== 1'b0 || b2 !== 1'b1) begin
      errors++;
      $display("FAIL sb_writeback cnt=%0d b3=%b b7=%b expected 1/0/1", cnt, b1, b2);
    end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    step();
    idle();
    rd_addr_1 = 5'd9;
    #1;
    checks++;
    if (cnt !== 6'd1 || d1 !== 32'h99 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_wb_idle cnt=%0d d9=%h b9=%b expected 1/99/0", cnt, d1, b1);
    end
  endtask

  task automatic test_collision();
    iss_en = 1'b1; iss_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    rd_addr_1 = 5'd4;
    #1;
    checks++;
    if (b1 !== 1'b1 || d1 !== 32'h55) begin
      errors++;
      $display("FAIL coll_same_cycle b4=%b d4=%h expected 1/55", b1, d1);
    end
    step();
    idle();
    #1;
    checks++;
    if (b1 !== 1'b1 || d1 !== 32'h55 || cnt !== 6'd2) begin
      errors++;
      $display("FAIL coll_iss_wb b4=%b d4=%h cnt=%0d expected 1/55/2", b1, d1, cnt);
    end
    iss_en = 1'b1; iss_addr = 5'd8; flush = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hAA;
    step();
    idle();
    rd_addr_1 = 5'd8; rd_addr_2 = 5'd10;
    #1;
    checks++;
    if (b1 !== 1'b0 || cnt !== 6'd0 || d2 !== 32'hAA) begin
      errors++;
      $display("FAIL coll_flush b8=%b cnt=%0d d10=%h expected 0/0/aa", b1, cnt, d2);
    end
    rd_addr_1 = 5'd4; rd_addr_2 = 5'd7;
    #1;
    checks++;
    if (b1 !== 1'b0 || b2 !== 1'b0) begin
      errors++;
      $display("FAIL coll_flush_all b4=%b b7=%b expected 0/0", b1, b2);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 1; i <= 10; i++) begin
      iss_en = 1'b1; iss_addr = 5'(i);
      step();
    end
    idle();
    checks++;
    if (cnt !== 6'd10) begin
      errors++;
      $display("FAIL mid_fill cnt=%0d expected=10", cnt);
    end
    #2;
    rst_i = 1'b0;
    rd_addr_1 = 5'd4; rd_addr_2 = 5'd29;
    #1;
    checks++;
    if (cnt !== 6'd0 || d1 !== 32'd0 || b1 !== 1'b0 || d2 !== 32'd128) begin
      errors++;
      $display("FAIL mid_reset cnt=%0d d4=%h b4=%b d29=%0d expected 0/0/0/128", cnt, d1, b1, d2);
    end
    rd_addr_1 = 5'd5;
    #1;
    checks++;
    if (d1 !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_r5 d5=%h expected=0", d1);
    end
    rst_i = 1'b1;
    iss_en = 1'b1; iss_addr = 5'd2;
    step();
    idle();
    rd_addr_1 = 5'd2;
    #1;
    checks++;
    if (cnt !== 6'd1 || b1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_first_edge cnt=%0d b2=%b expected 1/1", cnt, b1);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    rd_addr_1 = '0; rd_addr_2 = '0; wr_addr = '0; iss_addr = '0; wr_data = '0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth is 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as 0 and ignores writes and issues.
REQ-004 Parameter SP_IDX, default 29, index of the register with a non-zero reset value.
REQ-005 Parameter SP_RST, default 128, reset value of register SP_IDX.
REQ-006 Parameter BYPASS, default 1, when 1 a same-cycle write is forwarded to the read ports.
REQ-007 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_i  input  1  reset, asynchronous, active-low.
REQ-009 rd_addr_1_in, rd_addr_2_in  input  ADDR_W  read addresses.
REQ-010 rd_data_1_out, rd_data_2_out  output  DATA_W  combinational read data.
REQ-011 rd_busy_1_out, rd_busy_2_out  output  1  combinational: the addressed register has an outstanding producer.
REQ-012 wr_en_in  input  1  writeback strobe.
REQ-013 wr_addr_in  input  ADDR_W  writeback address.
REQ-014 wr_data_in  input  DATA_W  writeback data.
REQ-015 iss_en_in  input  1  issue strobe; marks iss_addr_in busy.
REQ-016 iss_addr_in  input  ADDR_W  destination of the issued instruction.
REQ-017 flush_in  input  1  synchronous clear of all busy bits.
REQ-018 busy_cnt_out  output  ADDR_W+1  registered count of busy registers.

Function
REQ-019 The block SHALL hold 2**ADDR_W data registers of DATA_W bits and one busy bit per register.
REQ-020 On a clock edge with wr_en_in=1, the block SHALL write wr_data_in to register wr_addr_in, except address 0 when ZERO_REG=1.
REQ-021 Reads SHALL be combinational; with ZERO_REG=1, address 0 SHALL return 0 and busy 0 regardless of any write or issue.
REQ-022 With BYPASS=1, a read port whose address equals wr_addr_in while wr_en_in=1 SHALL return wr_data_in in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-023 With BYPASS=1, a read port hitting an active write SHALL report busy 0 unless iss_en_in=1 to the same address in the same cycle.
REQ-024 iss_en_in=1 SHALL set busy[iss_addr_in] at the clock edge.
REQ-025 wr_en_in=1 SHALL clear busy[wr_addr_in] at the clock edge.
REQ-026 Issue and writeback to the same address in one cycle: set SHALL win, and the data write still occurs.
REQ-027 Issue to an already-busy register SHALL leave it busy with no count change.
REQ-028 Writeback to a non-busy register SHALL write data, leave busy clear and leave the count unchanged.
REQ-029 flush_in=1 SHALL clear every busy bit and zero busy_cnt_out at the edge, overriding same-cycle issue; a same-cycle data write SHALL still occur.
REQ-030 busy_cnt_out SHALL equal the number of set busy bits after every edge, updated by +1, -1 or 0 per cycle, never wrapping; maximum value 2**ADDR_W-1 with ZERO_REG=1, else 2**ADDR_W.
REQ-031 Data writes SHALL have one-cycle latency to the stored array; busy changes SHALL be visible on rd_busy outputs in the cycle after the edge.

Reset
REQ-032 rst_i=0 SHALL immediately, without a clock, set all registers to 0 except register SP_IDX to SP_RST, clear all busy bits, and set busy_cnt_out to 0.
REQ-033 While rst_i=0, writes, issues and flushes SHALL be ignored.
REQ-034 Reset asserted mid-operation SHALL discard outstanding busy state; after release, the first edge SHALL behave as a normal cycle.

Verification
REQ-035 Reset: assert rst_i=0 with no clock -> every register reads 0, R29 reads 128, all busy 0, busy_cnt_out=0.
REQ-036 Bypass: write R5=0xDEADBEEF with rd_addr_1_in=5 in the same cycle -> rd_data_1_out=0xDEADBEEF that cycle, stored value the next cycle; with BYPASS=0 -> old value 0 that cycle.
REQ-037 Zero register: write R0=0x1234 and issue R0 -> R0 reads 0, busy 0, busy_cnt_out stays 0.
REQ-038 Scoreboard: issue R3, R7 and R3 again -> busy_cnt_out=2; write R3 -> count 1 and rd_busy on R3 = 0; write R9 (not busy) -> count 1.
REQ-039 Collisions: issue R4 and write R4=0x55 in the same cycle -> R4 busy, reads 0x55, count +1; issue R8 with flush_in=1 -> all busy 0, count 0.
REQ-040 Mid-operation reset: 10 busy registers, assert rst_i low between edges -> count 0 and data restored to reset values immediately.
